// File: rtl/sccb_seq_pkg.sv
// sccb_seq_pkg
//   Shared definitions for the SCCB command sequencer:
//   - default SCCB word width and the OV camera device id (write address 8'h42)
//   - bit positions of the {dev, reg, val} fields inside a 24-bit SCCB word
//   - sequencer state encoding and command-source encoding
//   - sccb_word(): builds a word for the camera from a register/value pair
package sccb_seq_pkg;

   localparam int         SCCB_DATA_WIDTH = 24;
   localparam logic [7:0] DEV_ID          = 8'h42;

   // Field slices of an SCCB word {dev_id, reg, val}
   localparam int DEV_MSB = 23;
   localparam int DEV_LSB = 16;
   localparam int REG_MSB = 15;
   localparam int REG_LSB = 8;
   localparam int VAL_MSB = 7;
   localparam int VAL_LSB = 0;

   typedef enum logic [3:0] {
      ST_BOOT    = 4'd0,
      ST_FETCH   = 4'd1,
      ST_ISSUE_F = 4'd2,
      ST_ACK_F   = 4'd3,
      ST_DONE_F  = 4'd4,
      ST_ISSUE_R = 4'd5,
      ST_ACK_R   = 4'd6,
      ST_DONE_R  = 4'd7,
      ST_GAP     = 4'd8,
      ST_IDLE    = 4'd9
   } state_t;

   typedef enum logic {
      SRC_INIT = 1'b0,
      SRC_PS   = 1'b1
   } src_t;

   function automatic logic [SCCB_DATA_WIDTH-1:0] sccb_word(input logic [7:0] reg_addr,
                                                           input logic [7:0] reg_val);
      logic [SCCB_DATA_WIDTH-1:0] w;
      w                  = '0;
      w[DEV_MSB:DEV_LSB] = DEV_ID;
      w[REG_MSB:REG_LSB] = reg_addr;
      w[VAL_MSB:VAL_LSB] = reg_val;
      return w;
   endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// sccb_init_rom
//   Combinational table of the OV camera power-up register writes.
//   Ports:
//     idx   in   8            table index (0 .. INIT_LEN-1)
//     word  out  DATA_WIDTH   SCCB word {DEV_ID, reg, val}; 0 beyond INIT_LEN
//   The table holds 16 entries; INIT_LEN selects how many of them are replayed.
module sccb_init_rom
   import sccb_seq_pkg::*;
#(
   parameter int DATA_WIDTH = SCCB_DATA_WIDTH,
   parameter int INIT_LEN   = 16
) (
   input  logic [7:0]            idx,
   output logic [DATA_WIDTH-1:0] word
);

   logic [SCCB_DATA_WIDTH-1:0] entry;

   always_comb begin
      entry = '0;
      case (idx)
         8'd0:    entry = sccb_word(8'h12, 8'h80);  // COM7: soft reset
         8'd1:    entry = sccb_word(8'h11, 8'h01);  // CLKRC: prescaler
         8'd2:    entry = sccb_word(8'h12, 8'h04);  // COM7: RGB output
         8'd3:    entry = sccb_word(8'h0C, 8'h00);  // COM3
         8'd4:    entry = sccb_word(8'h3E, 8'h00);  // COM14
         8'd5:    entry = sccb_word(8'h40, 8'hD0);  // COM15: RGB565 full range
         8'd6:    entry = sccb_word(8'h3A, 8'h04);  // TSLB
         8'd7:    entry = sccb_word(8'h14, 8'h18);  // COM9: AGC ceiling
         8'd8:    entry = sccb_word(8'h4F, 8'hB3);  // MTX1
         8'd9:    entry = sccb_word(8'h50, 8'hB3);  // MTX2
         8'd10:   entry = sccb_word(8'h51, 8'h00);  // MTX3
         8'd11:   entry = sccb_word(8'h52, 8'h3D);  // MTX4
         8'd12:   entry = sccb_word(8'h53, 8'hA7);  // MTX5
         8'd13:   entry = sccb_word(8'h54, 8'hE4);  // MTX6
         8'd14:   entry = sccb_word(8'h3D, 8'hC0);  // COM13: gamma, UV sat
         8'd15:   entry = sccb_word(8'h1E, 8'h00);  // MVFP: no mirror/flip
         default: entry = '0;
      endcase
      if (int'(idx) >= INIT_LEN) entry = '0;
   end

   assign word = DATA_WIDTH'(entry);

endmodule

// File: rtl/sccb_cmd_sequencer.sv
// sccb_cmd_sequencer
//   Sole owner of the SCCB command path into the front and rear cam_top blocks.
//   After reset it waits BOOT_CYCLES, replays the init table to both cameras, then
//   serves PS register writes one at a time.
//   Ports:
//     clock        in   1    system clock (clk_12m)
//     n_rst        in   1    asynchronous active-low reset
//     ps_req       in   1    PS write request; rising edge detected
//     ps_data      in   DW   PS SCCB word, sampled on the rising-edge cycle
//     ps_busy      out  1    PS command pending/in flight, or init not finished
//     init_done    out  1    init table finished (sticky until reset)
//     sccb_data    out  DW   word presented to both cameras, stable req..done
//     sccb_req_f   out  1    one-cycle request pulse, front camera
//     sccb_req_r   out  1    one-cycle request pulse, rear camera
//     sccb_busy_f  in   1    front SCCB master busy
//     sccb_busy_r  in   1    rear SCCB master busy
//     err_timeout  out  1    sticky: a camera never raised busy in ACK_TIMEOUT cycles
//     err_overrun  out  1    sticky: ps_req edge dropped while ps_busy
//     dbg_state    out  4    current sequencer state
//   Build option: SCCB_BROADCAST_EN issues each command to both cameras at once
//   (shared ACK/DONE states); otherwise front then rear strictly in sequence.
//   Handshake: a camera accepts a command on its one-cycle req pulse and shows
//   acceptance by raising busy; the command is complete when busy falls again.
module sccb_cmd_sequencer
   import sccb_seq_pkg::*;
#(
   parameter int DATA_WIDTH  = SCCB_DATA_WIDTH,
   parameter int INIT_LEN    = 16,
   parameter int GAP_CYCLES  = 1200,
   parameter int BOOT_CYCLES = 12000,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                  clock,
   input  logic                  n_rst,
   input  logic                  ps_req,
   input  logic [DATA_WIDTH-1:0] ps_data,
   output logic                  ps_busy,
   output logic                  init_done,
   output logic [DATA_WIDTH-1:0] sccb_data,
   output logic                  sccb_req_f,
   output logic                  sccb_req_r,
   input  logic                  sccb_busy_f,
   input  logic                  sccb_busy_r,
   output logic                  err_timeout,
   output logic                  err_overrun,
   output state_t                dbg_state
);

   // One down-counter serves BOOT, GAP and ACK timeout, so it is sized for the largest.
   localparam int MAX_BG  = (BOOT_CYCLES > GAP_CYCLES) ? BOOT_CYCLES : GAP_CYCLES;
   localparam int MAX_CNT = (MAX_BG > ACK_TIMEOUT) ? MAX_BG : ACK_TIMEOUT;
   localparam int CNT_W   = $clog2(MAX_CNT) + 1;

   localparam logic [CNT_W-1:0] BOOT_LOAD = CNT_W'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACK_LOAD  = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [7:0]       LAST_IDX  = 8'(INIT_LEN - 1);

   state_t                state;
   src_t                  src;
   logic [CNT_W-1:0]      cnt;
   logic [7:0]            idx;
   logic                  pending;     // PS slot full, including while its command is in flight
   logic [DATA_WIDTH-1:0] slot_data;
   logic                  ps_req_d;
   logic [DATA_WIDTH-1:0] rom_word;

   logic ps_edge, gap_end, ps_finish, init_finish, accept, overrun, pending_nxt;

`ifdef SCCB_BROADCAST_EN
   logic seen_f, seen_r;   // busy already observed from each camera in ACK
`endif

   sccb_init_rom #(
      .DATA_WIDTH (DATA_WIDTH),
      .INIT_LEN   (INIT_LEN)
   ) u_rom (
      .idx  (idx),
      .word (rom_word)
   );

   // A PS command that finishes in the same cycle as a new edge frees the slot,
   // so the new request is latched instead of being counted as an overrun.
   always_comb begin
      ps_edge     = ps_req & ~ps_req_d;
      gap_end     = (state == ST_GAP) && (cnt == '0);
      ps_finish   = gap_end && (src == SRC_PS);
      init_finish = gap_end && (src == SRC_INIT) && (idx == LAST_IDX);
      accept      = ps_edge && (!pending || ps_finish);
      overrun     = ps_edge && pending && !ps_finish;
      pending_nxt = accept || (pending && !ps_finish);
   end

   assign dbg_state = state;

   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         state       <= ST_BOOT;
         src         <= SRC_INIT;
         cnt         <= BOOT_LOAD;
         idx         <= '0;
         pending     <= 1'b0;
         slot_data   <= '0;
         ps_req_d    <= 1'b0;
         ps_busy     <= 1'b0;
         init_done   <= 1'b0;
         sccb_data   <= '0;
         sccb_req_f  <= 1'b0;
         sccb_req_r  <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
`ifdef SCCB_BROADCAST_EN
         seen_f      <= 1'b0;
         seen_r      <= 1'b0;
`endif
      end else begin
         ps_req_d   <= ps_req;
         pending    <= pending_nxt;
         init_done  <= init_done | init_finish;
         ps_busy    <= pending_nxt | ~(init_done | init_finish);
         sccb_req_f <= 1'b0;
         sccb_req_r <= 1'b0;
         if (accept)  slot_data   <= ps_data;
         if (overrun) err_overrun <= 1'b1;

         case (state)
            ST_BOOT: begin
               if (cnt == '0) begin
                  state <= ST_FETCH;
                  idx   <= '0;
                  src   <= SRC_INIT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            // Request pulses are registered, so they are raised on entry to ISSUE.
            ST_FETCH: begin
               sccb_data  <= (src == SRC_PS) ? slot_data : rom_word;
               sccb_req_f <= 1'b1;
`ifdef SCCB_BROADCAST_EN
               sccb_req_r <= 1'b1;
`endif
               state      <= ST_ISSUE_F;
            end
            ST_ISSUE_F: begin
               cnt   <= ACK_LOAD;
               state <= ST_ACK_F;
`ifdef SCCB_BROADCAST_EN
               seen_f <= 1'b0;
               seen_r <= 1'b0;
`endif
            end
`ifdef SCCB_BROADCAST_EN
            ST_ACK_F: begin
               seen_f <= seen_f | sccb_busy_f;
               seen_r <= seen_r | sccb_busy_r;
               if ((seen_f | sccb_busy_f) && (seen_r | sccb_busy_r)) begin
                  state <= ST_DONE_F;
               end else if (cnt == '0) begin
                  err_timeout <= 1'b1;
                  state       <= ST_DONE_F;  // a silent camera is already idle
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE_F: begin
               if (!sccb_busy_f && !sccb_busy_r) begin
                  cnt   <= GAP_LOAD;
                  state <= ST_GAP;
               end
            end
`else
            ST_ACK_F: begin
               if (sccb_busy_f) begin
                  state <= ST_DONE_F;
               end else if (cnt == '0) begin
                  err_timeout <= 1'b1;
                  sccb_req_r  <= 1'b1;
                  state       <= ST_ISSUE_R;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE_F: begin
               if (!sccb_busy_f) begin
                  sccb_req_r <= 1'b1;
                  state      <= ST_ISSUE_R;
               end
            end
            ST_ISSUE_R: begin
               cnt   <= ACK_LOAD;
               state <= ST_ACK_R;
            end
            ST_ACK_R: begin
               if (sccb_busy_r) begin
                  state <= ST_DONE_R;
               end else if (cnt == '0) begin
                  err_timeout <= 1'b1;
                  cnt         <= GAP_LOAD;
                  state       <= ST_GAP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE_R: begin
               if (!sccb_busy_r) begin
                  cnt   <= GAP_LOAD;
                  state <= ST_GAP;
               end
            end
`endif
            ST_GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (src == SRC_INIT && idx != LAST_IDX) begin
                  idx   <= idx + 1'b1;
                  state <= ST_FETCH;
               end else if (src == SRC_INIT && pending) begin
                  // a PS write queued during init goes out right after the last entry
                  src   <= SRC_PS;
                  state <= ST_FETCH;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (pending) begin
                  src   <= SRC_PS;
                  state <= ST_FETCH;
               end
            end
            default: state <= ST_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_sccb_cmd_sequencer.sv
// tb_sccb_cmd_sequencer
//   Bench for sccb_cmd_sequencer with BOOT_CYCLES=20, GAP_CYCLES=8, INIT_LEN=3.
//   Camera models raise busy one cycle after their req pulse and hold it 30 cycles.
//   The driver pushes every word the cameras should receive into per-camera
//   expected queues; the monitor pops them on each req pulse. Direct status
//   checks from the driver are posted to a check queue that the monitor evaluates.
module tb_sccb_cmd_sequencer;
   import sccb_seq_pkg::*;

   localparam int INIT_LEN = 3;
   localparam int BOOT_CYC = 20;
   localparam int GAP_CYC  = 8;
   localparam int ACK_TO   = 255;
   localparam int BUSY_LEN = 30;

   logic        clock = 1'b0;
   logic        n_rst = 1'b0;
   logic        ps_req = 1'b0;
   logic [23:0] ps_data = '0;
   logic        ps_busy, init_done, sccb_req_f, sccb_req_r, err_timeout, err_overrun;
   logic [23:0] sccb_data;
   logic        busy_f, busy_r;
   state_t      dbg_state;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   sccb_cmd_sequencer #(
      .DATA_WIDTH  (24),
      .INIT_LEN    (INIT_LEN),
      .GAP_CYCLES  (GAP_CYC),
      .BOOT_CYCLES (BOOT_CYC),
      .ACK_TIMEOUT (ACK_TO)
   ) dut (
      .clock       (clock),
      .n_rst       (n_rst),
      .ps_req      (ps_req),
      .ps_data     (ps_data),
      .ps_busy     (ps_busy),
      .init_done   (init_done),
      .sccb_data   (sccb_data),
      .sccb_req_f  (sccb_req_f),
      .sccb_req_r  (sccb_req_r),
      .sccb_busy_f (busy_f),
      .sccb_busy_r (busy_r),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun),
      .dbg_state   (dbg_state)
   );

   // ---------------- camera models ----------------
   logic rear_dead = 1'b0;
   int   bf_cnt, br_cnt;

   always @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         busy_f <= 1'b0;
         bf_cnt <= 0;
      end else if (sccb_req_f) begin
         busy_f <= 1'b1;
         bf_cnt <= BUSY_LEN - 1;
      end else if (bf_cnt > 0) begin
         bf_cnt <= bf_cnt - 1;
      end else begin
         busy_f <= 1'b0;
      end
   end

   always @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         busy_r <= 1'b0;
         br_cnt <= 0;
      end else if (sccb_req_r && !rear_dead) begin
         busy_r <= 1'b1;
         br_cnt <= BUSY_LEN - 1;
      end else if (br_cnt > 0) begin
         br_cnt <= br_cnt - 1;
      end else begin
         busy_r <= 1'b0;
      end
   end

   // ---------------- reference model ----------------
   // Init table contents as documented for the camera power-up sequence.
   logic [23:0] rom_tab [0:INIT_LEN-1] = '{24'h421280, 24'h421101, 24'h421204};
   logic [23:0] exp_f_q[$];
   logic [23:0] exp_r_q[$];
   logic        model_overrun = 1'b0;

   function automatic void model_reset();
      exp_f_q.delete();
      exp_r_q.delete();
      model_overrun = 1'b0;
      for (int i = 0; i < INIT_LEN; i++) begin
         exp_f_q.push_back(rom_tab[i]);
         exp_r_q.push_back(rom_tab[i]);
      end
   endfunction

   function automatic void model_accept(input logic [23:0] d);
      exp_f_q.push_back(d);
      exp_r_q.push_back(d);
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } chk_t;

   chk_t chk_q[$];
   int   checks = 0;
   int   failures = 0;
   int   num_f = 0;
   int   num_r = 0;

   function automatic void post(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_t c;
      c.name = name;
      c.act  = act;
      c.exp  = exp;
      chk_q.push_back(c);
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   logic [23:0] held_f, held_r;
   logic        prev_bf = 1'b0;
   logic        prev_br = 1'b0;

   always @(negedge clock) begin
      while (chk_q.size() > 0) begin
         chk_t c;
         c = chk_q.pop_front();
         cmp(c.name, c.act, c.exp);
      end
      if (!n_rst) begin
         prev_bf = 1'b0;
         prev_br = 1'b0;
         num_f   = 0;
         num_r   = 0;
      end else begin
         if (sccb_req_f) begin
            num_f++;
            held_f = sccb_data;
            if (exp_f_q.size() == 0) cmp("front_word_unexpected", {8'h0, sccb_data}, 32'hFFFF_FFFF);
            else cmp("front_word", {8'h0, sccb_data}, {8'h0, exp_f_q.pop_front()});
         end
         if (sccb_req_r) begin
            num_r++;
            held_r = sccb_data;
            if (exp_r_q.size() == 0) cmp("rear_word_unexpected", {8'h0, sccb_data}, 32'hFFFF_FFFF);
            else cmp("rear_word", {8'h0, sccb_data}, {8'h0, exp_r_q.pop_front()});
         end
`ifdef SCCB_BROADCAST_EN
         if (sccb_req_f || sccb_req_r) cmp("req_together", {31'h0, sccb_req_f}, {31'h0, sccb_req_r});
`else
         if (sccb_req_f || sccb_req_r) cmp("req_exclusive", {31'h0, sccb_req_f & sccb_req_r}, 32'h0);
`endif
         if (prev_bf && !busy_f) cmp("front_data_held", {8'h0, sccb_data}, {8'h0, held_f});
         if (prev_br && !busy_r) cmp("rear_data_held", {8'h0, sccb_data}, {8'h0, held_r});
         prev_bf = busy_f;
         prev_br = busy_r;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ps_pulse(input logic [23:0] d, input int width);
      ps_data = d;
      ps_req  = 1'b1;
      repeat (width) tick();
      ps_req  = 1'b0;
      ps_data = 24'($urandom);   // must not matter after the edge cycle
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (ps_busy !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
      post(name, {31'h0, ps_busy}, 32'h0);
   endtask

   task automatic wait_init(input string name, input int budget);
      int n;
      n = 0;
      while (init_done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      post(name, {31'h0, init_done}, 32'h1);
   endtask

   task automatic post_reset_outputs(input string tag);
      post({tag, "_ps_busy"},     {31'h0, ps_busy},     32'h0);
      post({tag, "_init_done"},   {31'h0, init_done},   32'h0);
      post({tag, "_req_f"},       {31'h0, sccb_req_f},  32'h0);
      post({tag, "_req_r"},       {31'h0, sccb_req_r},  32'h0);
      post({tag, "_sccb_data"},   {8'h0, sccb_data},    32'h0);
      post({tag, "_err_timeout"}, {31'h0, err_timeout}, 32'h0);
      post({tag, "_err_overrun"}, {31'h0, err_overrun}, 32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [23:0] d;
      int          n, lat;

      // Reset state
      n_rst = 1'b0;
      repeat (3) tick();
      post_reset_outputs("rst");
      model_reset();
      n_rst = 1'b1;
      tick();
      post("ps_busy_after_rst", {31'h0, ps_busy}, 32'h1);

      // PS request while the second init entry is being sent: queued behind init
      n = 0;
      while (num_f < 2 && n < 1000) begin
         tick();
         n++;
      end
      post("init_second_entry_seen", num_f, 2);
      d = 24'($urandom);
      model_accept(d);
      ps_pulse(d, $urandom_range(1, 4));

      wait_init("init_done_rise", 2000);
      post("init_front_count", num_f, INIT_LEN);
      post("init_rear_count", num_r, INIT_LEN);
      post("busy_with_queued_req", {31'h0, ps_busy}, 32'h1);
      wait_idle("idle_after_queued_req", 1000);
      post("no_overrun_queued", {31'h0, err_overrun}, 32'h0);

      // Latency from IDLE: edge cycle -> front req three cycles later
      d = 24'h421280;
      model_accept(d);
      ps_data = d;
      ps_req  = 1'b1;
      lat = 0;
      while (lat < 10) begin
         tick();
         lat++;
         if (sccb_req_f) break;
      end
      post("req_latency", lat, 3);
      post("busy_in_flight", {31'h0, ps_busy}, 32'h1);
      ps_req = 1'b0;
      wait_idle("idle_after_latency", 1000);

      // Randomized PS writes; the first one always attempts a second edge in flight
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 5)) tick();
         d = 24'($urandom);
         model_accept(d);
         ps_pulse(d, $urandom_range(1, 5));
         if (i == 0 || $urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(2, 20)) tick();
            ps_pulse(24'($urandom), $urandom_range(1, 3));
            model_overrun = 1'b1;
         end
         wait_idle("idle_random", 1000);
         post("err_overrun", {31'h0, err_overrun}, {31'h0, model_overrun});
      end
      post("no_timeout_yet", {31'h0, err_timeout}, 32'h0);

      // Rear camera silent: timeout, sequencer still returns to IDLE
      rear_dead = 1'b1;
      d = 24'($urandom);
      model_accept(d);
      ps_pulse(d, 1);
      wait_idle("idle_after_timeout", 1500);
      post("err_timeout", {31'h0, err_timeout}, 32'h1);
      post("idle_state", {28'h0, dbg_state}, {28'h0, ST_IDLE});
      rear_dead = 1'b0;

      // Normal write still works after a timeout
      d = 24'($urandom);
      model_accept(d);
      ps_pulse(d, 2);
      wait_idle("idle_after_recover", 1000);

      // Reset while the rear camera is busy: outputs clear, init replays
      d = 24'($urandom);
      model_accept(d);
      ps_pulse(d, 1);
      n = 0;
      while (sccb_req_r !== 1'b1 && n < 500) begin
         tick();
         n++;
      end
      post("rear_req_before_reset", {31'h0, sccb_req_r}, 32'h1);
      repeat (5) tick();
      n_rst = 1'b0;
      #1;
      post_reset_outputs("midcmd_rst");
      repeat (2) tick();
      model_reset();
      n_rst = 1'b1;
      wait_init("init_replay", 2000);
      post("replay_front_count", num_f, INIT_LEN);
      post("replay_rear_count", num_r, INIT_LEN);
      wait_idle("idle_after_replay", 200);
      post("replay_no_errors", {30'h0, err_timeout, err_overrun}, 32'h0);

      repeat (5) tick();
      post("front_queue_drained", exp_f_q.size(), 0);
      post("rear_queue_drained", exp_r_q.size(), 0);
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
